conf_mem_arb: RTL
=================

// Module: conf_mem_arb
// PURPOSE
//  Two-port round-robin arbiter/sequencer in front of a single-port video-IP config memory.
//  Port 0 serves the host register bus; port 1 serves the internal frame sequencer.
//  Turns each req/ack transaction into a correctly timed adr/wdt/val cycle.
//  Collects the memory's 1-cycle registered read data.
//  Rejects writes to out-of-range or direct-mapped (read-only) registers.
// PARAMETERS
//  DW_MA       8   address width
//  DW_MD       16  data width
//  NUM_OF_REG  4   implemented registers; addresses >= NUM_OF_REG are out of range
//  DIR_M       0   [NUM_OF_REG-1:0] mask; bit i=1 -> register i is direct-mapped (writes rejected)
// PORTS
//  clk       in   1      clock
//  rstb      in   1      reset, asynchronous, active-low
//  r0_req    in   1      port0 request; held with r0_we/adr/wdt stable until r0_ack
//  r0_we     in   1      port0 1=write 0=read
//  r0_adr    in   DW_MA  port0 address
//  r0_wdt    in   DW_MD  port0 write data
//  r0_ack    out  1      port0 completion, 1-cycle pulse
//  r0_rdt    out  DW_MD  port0 read data, valid while r0_ack=1
//  r0_err    out  1      port0 error flag, valid while r0_ack=1
//  r1_*      --   --     identical set for port1
//  m_adr     out  DW_MA  memory address
//  m_wdt     out  DW_MD  memory write data
//  m_val     out  1      memory write strobe
//  m_rdt     in   DW_MD  memory read data (registered in memory, 1-cycle latency from m_adr)
// BEHAVIOUR
//  Reset values: all outputs 0; FSM=IDLE; last-grant pointer lst=1, so port0 wins the first tie.
//  FSM IDLE -> ACC -> RSP -> IDLE:
//   IDLE  Eligible port = req=1 and its ack not asserted this cycle.
//         On an eligible request: latch gnt, we, adr, wdt into m_adr/m_wdt; go ACC.
//         Compute ok = (adr<NUM_OF_REG) && !(we && DIR_M[adr]).
//         Set m_val = we&&ok.
//   ACC   Memory performs the write and registers rdt.
//         m_val is cleared at the ACC->RSP edge, so m_val is high for exactly one cycle; go RSP.
//   RSP   Capture rN_rdt <= ok ? m_rdt : 0, rN_err <= !ok, rN_ack <= 1 for the granted port.
//         Go IDLE.
//  Ack is visible the cycle after RSP: req-sample edge to ack-visible = 3 clocks.
//  IDLE suppresses the acked port's still-high req for that one cycle.
//  The other port may be granted in the ack cycle.
//  Arbitration:
//   - Only one port eligible -> grant it.
//   - Both eligible -> grant !lst; lst updates on every grant.
//   - Strict alternation under continuous load; no starvation.
//  Writes return the pre-write register contents on rN_rdt; err=0 when ok.
//  Reads of a direct-mapped address are legal and return the live value; err=0.
//  Out-of-range read: rdt=0, err=1, m_val stays 0.
//  Rejected write: err=1, m_val stays 0.
//  m_adr/m_wdt hold their last granted values outside transactions; no X propagation.
//  Request withdrawn before ack: protocol violation. The arbiter completes the latched transaction anyway.
//  Reset mid-transaction: all state clears immediately.
//   - No ack is issued; m_val drops at once.
//   - A pending write lands only if its ACC edge preceded the reset.
//  rN_rdt/rN_err hold between acks; they are meaningful only with ack.
// STRUCTURE
//  conf_arb_defs.vh holds:
//   - state encodings ST_IDLE=2'd0, ST_ACC=2'd1, ST_RSP=2'd2
//   - port index localparams P_HOST=0, P_SEQ=1
//  Sub-module rr_arb2: combinational 2-way round-robin pick.
//   - inputs: req[1:0] (already eligibility-masked), lst
//   - outputs: gnt_vld, gnt_idx
//  Top holds the FSM, the lst register, the transaction latch and the response registers.
// TESTING
//  1 Reset, then r0 writes adr=1 wdt=16'hA5A5 -> m_val high 1 cycle with m_adr=1.
//    r0_ack 3 clocks after req sampled; err=0; rdt=DEF value.
//  2 r0 reads adr=1 after test 1 -> r0_rdt=16'hA5A5, err=0, m_val never asserted.
//  3 r0 and r1 read adr 0 and 2, both holding req for 4 transactions each.
//    -> grants alternate P0,P1,P0,P1...; first grant P0; each ack carries the correct data.
//  4 With DIR_M=4'b1000: write adr=3 -> err=1, m_val=0.
//    Write adr=8 -> err=1, m_val=0.
//    Read adr=3 -> err=0, rdt=live m3 value.
//  5 Assert rstb=0 during ACC of an r1 write -> r1_ack never pulses.
//    All outputs 0 immediately; after release, port0 wins the first tie.
//  6 r0 holds req high through its ack -> no double grant in the ack cycle.
//    A second transaction is accepted on the following edge.

Source files
------------

// File: rtl/conf_mem_arb_pkg.sv
// Shared types and constants for the config-memory arbiter.
`default_nettype none

package conf_mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_RSP  = 2'd2
  } state_e;

  localparam int P_HOST = 0;
  localparam int P_SEQ  = 1;

endpackage

`default_nettype wire

// File: rtl/conf_mem_arb_rr_arb2.sv
// Combinational 2-way round-robin pick; inputs are already eligibility-masked.
`default_nettype none

module rr_arb2
  import conf_mem_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       lst_i,
  output logic       gnt_vld_o,
  output logic       gnt_idx_o
);

  // On a tie the port that did not win last time goes next.
  assign gnt_vld_o = |req_i;
  assign gnt_idx_o = (&req_i) ? ~lst_i : req_i[P_SEQ];

endmodule

`default_nettype wire

// File: rtl/conf_mem_arb.sv
// Two-port round-robin sequencer in front of a single-port config memory with 1-cycle read latency.
`default_nettype none

module conf_mem_arb
  import conf_mem_arb_pkg::*;
#(
  parameter int                    DW_MA      = 8,
  parameter int                    DW_MD      = 16,
  parameter int                    NUM_OF_REG = 4,
  parameter logic [NUM_OF_REG-1:0] DIR_M      = '0
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             r0_req,
  input  logic             r0_we,
  input  logic [DW_MA-1:0] r0_adr,
  input  logic [DW_MD-1:0] r0_wdt,
  output logic             r0_ack,
  output logic [DW_MD-1:0] r0_rdt,
  output logic             r0_err,
  input  logic             r1_req,
  input  logic             r1_we,
  input  logic [DW_MA-1:0] r1_adr,
  input  logic [DW_MD-1:0] r1_wdt,
  output logic             r1_ack,
  output logic [DW_MD-1:0] r1_rdt,
  output logic             r1_err,
  output logic [DW_MA-1:0] m_adr,
  output logic [DW_MD-1:0] m_wdt,
  output logic             m_val,
  input  logic [DW_MD-1:0] m_rdt
);

  state_e           state_q;
  logic             lst_q;
  logic             gnt_q;
  logic             ok_q;
  logic [DW_MA-1:0] m_adr_q;
  logic [DW_MD-1:0] m_wdt_q;
  logic             m_val_q;
  logic             r0_ack_q, r1_ack_q;
  logic [DW_MD-1:0] r0_rdt_q, r1_rdt_q;
  logic             r0_err_q, r1_err_q;

  logic [1:0]       elig;
  logic             gnt_vld;
  logic             gnt_idx;
  logic             sel_we;
  logic [DW_MA-1:0] sel_adr;
  logic [DW_MD-1:0] sel_wdt;
  logic             sel_hit;
  logic             sel_dir;
  logic             sel_ok;
  logic [DW_MD-1:0] rsp_rdt;

  // A port whose ack is showing this cycle is masked so its held req is not re-granted.
  assign elig = {r1_req & ~r1_ack_q, r0_req & ~r0_ack_q};

  rr_arb2 u_arb (
    .req_i     (elig),
    .lst_i     (lst_q),
    .gnt_vld_o (gnt_vld),
    .gnt_idx_o (gnt_idx)
  );

  assign sel_we  = gnt_idx ? r1_we  : r0_we;
  assign sel_adr = gnt_idx ? r1_adr : r0_adr;
  assign sel_wdt = gnt_idx ? r1_wdt : r0_wdt;

  always_comb begin
    sel_hit = 1'b0;
    sel_dir = 1'b0;
    for (int i = 0; i < NUM_OF_REG; i++) begin
      if (sel_adr == DW_MA'(i)) begin
        sel_hit = 1'b1;
        sel_dir = DIR_M[i];
      end
    end
  end

  assign sel_ok  = sel_hit && !(sel_we && sel_dir);
  assign rsp_rdt = ok_q ? m_rdt : '0;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q  <= ST_IDLE;
      lst_q    <= 1'b1;
      gnt_q    <= 1'b0;
      ok_q     <= 1'b0;
      m_adr_q  <= '0;
      m_wdt_q  <= '0;
      m_val_q  <= 1'b0;
      r0_ack_q <= 1'b0;
      r1_ack_q <= 1'b0;
      r0_rdt_q <= '0;
      r1_rdt_q <= '0;
      r0_err_q <= 1'b0;
      r1_err_q <= 1'b0;
    end else begin
      r0_ack_q <= 1'b0;
      r1_ack_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (gnt_vld) begin
            gnt_q   <= gnt_idx;
            lst_q   <= gnt_idx;
            ok_q    <= sel_ok;
            m_adr_q <= sel_adr;
            m_wdt_q <= sel_wdt;
            m_val_q <= sel_we && sel_ok;
            state_q <= ST_ACC;
          end
        end
        ST_ACC: begin
          m_val_q <= 1'b0;
          state_q <= ST_RSP;
        end
        ST_RSP: begin
          if (gnt_q == 1'(P_SEQ)) begin
            r1_ack_q <= 1'b1;
            r1_rdt_q <= rsp_rdt;
            r1_err_q <= !ok_q;
          end else begin
            r0_ack_q <= 1'b1;
            r0_rdt_q <= rsp_rdt;
            r0_err_q <= !ok_q;
          end
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign m_adr  = m_adr_q;
  assign m_wdt  = m_wdt_q;
  assign m_val  = m_val_q;
  assign r0_ack = r0_ack_q;
  assign r0_rdt = r0_rdt_q;
  assign r0_err = r0_err_q;
  assign r1_ack = r1_ack_q;
  assign r1_rdt = r1_rdt_q;
  assign r1_err = r1_err_q;

endmodule

`default_nettype wire
